// File: rtl/ioctl_sched.sv
// Routes loader downloads to a buffered ROM write port, a mod register and a DIP bank,
// and sequences core reset around ROM loads. Optional rom_sum output: IOCTL_SCHED_ROMSUM_EN.
module ioctl_sched #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  input  logic        dn_ready,
  output logic [7:0]  mod,
  output logic [63:0] sw,
  output logic        core_reset,
  output logic        overflow
`ifdef IOCTL_SCHED_ROMSUM_EN
  ,
  output logic [15:0] rom_sum
`endif
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned HCW = $clog2(HOLD_CYCLES + 1);
  localparam logic [AW:0] FullOcc  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] WaitOcc  = (AW + 1)'(FIFO_DEPTH - 1);
  localparam logic [HCW-1:0] HoldLast = HCW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StHold} state_e;

  state_e         state_q, state_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic           core_reset_q;

  logic [23:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [AW:0]    fcnt_q, fcnt_d;
  logic           out_valid_q, out_valid_d;
  logic [15:0]    out_addr_q, out_addr_d;
  logic [7:0]     out_data_q, out_data_d;
  logic           wait_q, wait_d;
  logic           overflow_q, overflow_d;
  logic           dl_q;
  logic [7:0]     mod_q, mod_d;
  logic [63:0]    sw_q, sw_d;

  logic rom_sel, push_req, xfer, reg_free, fifo_empty, full;
  logic accept, drop, bypass, pop, fifo_wr, dl_rise_rom;
  logic [AW:0] occ_q, occ_d;

  assign rom_sel     = (ioctl_index == 8'd0);
  assign push_req    = ioctl_wr & rom_sel & (ioctl_addr[24:16] == 9'd0);
  assign xfer        = out_valid_q & dn_ready;
  assign reg_free    = ~out_valid_q | xfer;
  assign fifo_empty  = (fcnt_q == '0);
  // Occupancy counts the output register, so FIFO_DEPTH writes in total can be outstanding.
  assign occ_q       = fcnt_q + {{AW{1'b0}}, out_valid_q};
  assign full        = (occ_q == FullOcc);
  assign accept      = push_req & (~full | xfer);
  assign drop        = push_req & ~accept;
  assign bypass      = accept & reg_free & fifo_empty;
  assign pop         = reg_free & ~fifo_empty;
  assign fifo_wr     = accept & ~bypass;
  assign dl_rise_rom = ioctl_download & ~dl_q & rom_sel;

  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    fcnt_d      = fcnt_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_addr_d  = mem_q[rptr_q][23:8];
      out_data_d  = mem_q[rptr_q][7:0];
    end else if (bypass) begin
      out_valid_d = 1'b1;
      out_addr_d  = ioctl_addr[15:0];
      out_data_d  = ioctl_dout;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
    unique case ({fifo_wr, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
    occ_d      = fcnt_d + {{AW{1'b0}}, out_valid_d};
    wait_d     = (occ_d >= WaitOcc);
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (dl_rise_rom) begin
      overflow_d = 1'b0;
    end
  end

  always_comb begin
    mod_d = mod_q;
    sw_d  = sw_q;
    if (ioctl_wr && ioctl_index == 8'd1) begin
      mod_d = ioctl_dout;
    end
    if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr[24:3] == 22'd0) begin
      sw_d[{ioctl_addr[2:0], 3'b000} +: 8] = ioctl_dout;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (ioctl_download && rom_sel) state_d = StLoad;
      end
      StLoad: begin
        if (!ioctl_download) state_d = StDrain;
      end
      StDrain: begin
        if (fifo_empty && !out_valid_q) begin
          state_d    = StHold;
          hold_cnt_d = '0;
        end
      end
      StHold: begin
        if (ioctl_download && rom_sel) begin
          state_d = StLoad;
        end else if (hold_cnt_q == HoldLast) begin
          state_d = StIdle;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = StHold;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      fcnt_q       <= '0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      wait_q       <= 1'b0;
      overflow_q   <= 1'b0;
      dl_q         <= 1'b0;
      mod_q        <= '0;
      sw_q         <= '1;
      state_q      <= StHold;
      hold_cnt_q   <= '0;
      core_reset_q <= 1'b1;
    end else begin
      if (fifo_wr) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      fcnt_q       <= fcnt_d;
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      wait_q       <= wait_d;
      overflow_q   <= overflow_d;
      dl_q         <= ioctl_download;
      mod_q        <= mod_d;
      sw_q         <= sw_d;
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      core_reset_q <= (state_d != StIdle);
    end
  end

  // Storage needs no reset: pointers and count define validity.
  always_ff @(posedge clk_sys) begin
    if (fifo_wr) mem_q[wptr_q] <= {ioctl_addr[15:0], ioctl_dout};
  end

`ifdef IOCTL_SCHED_ROMSUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = (state_d == StLoad && state_q != StLoad) ? 16'h0000 : sum_q;
    if (xfer && state_q != StIdle) sum_d = sum_d + {8'h00, out_data_q};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) sum_q <= '0;
    else          sum_q <= sum_d;
  end

  assign rom_sum = sum_q;
`endif

  assign ioctl_wait = wait_q;
  assign dn_wr      = out_valid_q;
  assign dn_addr    = out_addr_q;
  assign dn_data    = out_data_q;
  assign mod        = mod_q;
  assign sw         = sw_q;
  assign core_reset = core_reset_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ioctl_sched.sv
// Directed bench for ioctl_sched: register-write vector table plus hand-written
// sequences for ROM streaming, back-pressure, drain/hold timing and reset abort.
module tb_ioctl_sched;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        dn_ready = 1'b0;
  logic [7:0]  mod;
  logic [63:0] sw;
  logic        core_reset;
  logic        overflow;
`ifdef IOCTL_SCHED_ROMSUM_EN
  logic [15:0] rom_sum;
`endif

  ioctl_sched #(.FIFO_DEPTH(4), .HOLD_CYCLES(16)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .dn_ready       (dn_ready),
    .mod            (mod),
    .sw             (sw),
    .core_reset     (core_reset),
    .overflow       (overflow)
`ifdef IOCTL_SCHED_ROMSUM_EN
    ,
    .rom_sum        (rom_sum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned cyc = 0;
  logic [23:0] xq[$];
  int unsigned xc[$];

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Transfer log: values read here are the pre-edge ones being accepted.
  always @(posedge clk_sys) begin
    if (reset_n && dn_wr && dn_ready) begin
      xq.push_back({dn_addr, dn_data});
      xc.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (core_reset && k < 100) begin
      @(negedge clk_sys);
      k++;
    end
    check(name, 64'(core_reset), 64'd0);
  endtask

  typedef struct {
    logic        dl;
    logic [7:0]  idx;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic [7:0]  exp_mod;
    logic [63:0] exp_sw;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned first_cyc;
    int unsigned errs;

    vecs[0] = '{1'b1, 8'd1,   25'd0,       8'h03, 8'h03, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[1] = '{1'b1, 8'd1,   25'd5,       8'hA7, 8'hA7, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2] = '{1'b1, 8'd254, 25'd2,       8'h5A, 8'hA7, 64'hFFFF_FFFF_FF5A_FFFF};
    vecs[3] = '{1'b1, 8'd254, 25'd9,       8'h00, 8'hA7, 64'hFFFF_FFFF_FF5A_FFFF};
    vecs[4] = '{1'b1, 8'd254, 25'd7,       8'h12, 8'hA7, 64'h12FF_FFFF_FF5A_FFFF};
    vecs[5] = '{1'b0, 8'd0,   25'h10000,   8'h77, 8'hA7, 64'h12FF_FFFF_FF5A_FFFF};
    vecs[6] = '{1'b1, 8'd254, 25'd0,       8'h00, 8'hA7, 64'h12FF_FFFF_FF5A_FF00};

    // Reset values
    #12;
    check("rst_dn_wr", 64'(dn_wr), 64'd0);
    check("rst_dn_addr", 64'(dn_addr), 64'd0);
    check("rst_dn_data", 64'(dn_data), 64'd0);
    check("rst_wait", 64'(ioctl_wait), 64'd0);
    check("rst_mod", 64'(mod), 64'd0);
    check("rst_sw", sw, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_core_reset", 64'(core_reset), 64'd1);

    // Post-reset hold of exactly 16 cycles
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (15) @(negedge clk_sys);
    check("hold15_core_reset", 64'(core_reset), 64'd1);
    @(negedge clk_sys);
    check("hold16_core_reset", 64'(core_reset), 64'd0);

    // mod / DIP / discarded ROM vectors
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_sys);
      ioctl_download = vecs[i].dl;
      ioctl_index    = vecs[i].idx;
      ioctl_addr     = vecs[i].addr;
      ioctl_dout     = vecs[i].dout;
      ioctl_wr       = 1'b1;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      check($sformatf("vec%0d_mod", i), 64'(mod), 64'(vecs[i].exp_mod));
      check($sformatf("vec%0d_sw", i), sw, vecs[i].exp_sw);
      check($sformatf("vec%0d_core_reset", i), 64'(core_reset), 64'd0);
      check($sformatf("vec%0d_dn_wr", i), 64'(dn_wr), 64'd0);
    end
    ioctl_download = 1'b0;

    // 256-byte ROM stream with dn_ready held high
    dn_ready = 1'b1;
    xq.delete();
    xc.delete();
    @(negedge clk_sys);
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    check("load_core_reset", 64'(core_reset), 64'd1);
    first_cyc = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk_sys);
      if (i == 0) first_cyc = cyc;
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = 8'(i);
    end
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("stream_count", 64'(xq.size()), 64'd256);
    errs = 0;
    for (int i = 0; i < xq.size(); i++) if (xq[i] !== {16'(i), 8'(i)}) errs++;
    check("stream_order_errs", 64'(errs), 64'd0);
    if (xc.size() > 0) check("stream_first_latency", 64'(xc[0] - first_cyc), 64'd1);
    else check("stream_first_latency", 64'd0, 64'd1);
    check("stream_overflow", 64'(overflow), 64'd0);
`ifdef IOCTL_SCHED_ROMSUM_EN
    check("stream_rom_sum", 64'(rom_sum), 64'h7F80);
`endif
    wait_idle("stream_hold_end");

    // Back-pressure and overflow
    dn_ready = 1'b0;
    xq.delete();
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys);
      if (i == 2) check("bp_wait_after2", 64'(ioctl_wait), 64'd0);
      if (i == 3) check("bp_wait_after3", 64'(ioctl_wait), 64'd1);
      if (i == 4) check("bp_overflow_before5", 64'(overflow), 64'd0);
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(16'h0100 + i);
      ioctl_dout = 8'(8'hA0 + i);
    end
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    check("bp_overflow", 64'(overflow), 64'd1);
    check("bp_dn_wr_held", 64'(dn_wr), 64'd1);
    check("bp_dn_addr_held", 64'(dn_addr), 64'h0100);
    check("bp_dn_data_held", 64'(dn_data), 64'hA0);
    dn_ready = 1'b1;
    repeat (6) @(negedge clk_sys);
    check("bp_count", 64'(xq.size()), 64'd4);
    errs = 0;
    for (int i = 0; i < xq.size(); i++) if (xq[i] !== {16'(16'h0100 + i), 8'(8'hA0 + i)}) errs++;
    check("bp_order_errs", 64'(errs), 64'd0);
    check("bp_wait_clear", 64'(ioctl_wait), 64'd0);
    check("bp_overflow_sticky", 64'(overflow), 64'd1);
    ioctl_download = 1'b0;
    wait_idle("bp_hold_end");

    // Drain with stalled port, then exact hold length
    dn_ready = 1'b0;
    xq.delete();
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    check("drain_overflow_cleared", 64'(overflow), 64'd0);
    for (int i = 0; i < 2; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(16'h0200 + i);
      ioctl_dout = 8'(8'h30 + i);
      @(negedge clk_sys);
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    repeat (5) @(negedge clk_sys);
    check("drain_core_reset", 64'(core_reset), 64'd1);
    check("drain_dn_wr", 64'(dn_wr), 64'd1);
    check("drain_no_xfer", 64'(xq.size()), 64'd0);
    dn_ready = 1'b1;
    repeat (18) @(negedge clk_sys);
    check("drain_count", 64'(xq.size()), 64'd2);
    check("drain_hold_last", 64'(core_reset), 64'd1);
    @(negedge clk_sys);
    check("drain_hold_done", 64'(core_reset), 64'd0);

    // Reset during LOAD discards pending writes
    dn_ready = 1'b0;
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(16'h0300 + i);
      ioctl_dout = 8'(8'h50 + i);
    end
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    check("abort_dn_wr_before", 64'(dn_wr), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_dn_wr_async", 64'(dn_wr), 64'd0);
    check("abort_wait_async", 64'(ioctl_wait), 64'd0);
    check("abort_core_reset", 64'(core_reset), 64'd1);
    check("abort_mod_async", 64'(mod), 64'd0);
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    reset_n = 1'b1;
    xq.delete();
    dn_ready = 1'b1;
    repeat (25) @(negedge clk_sys);
    check("abort_no_stale_xfer", 64'(xq.size()), 64'd0);
    check("abort_core_reset_done", 64'(core_reset), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ioctl_sched.md
IOCTL_SCHED -- requirements
Module: ioctl_sched

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: depth of the ROM write buffer, in entries (power of two, minimum 4).
REQ-002 Parameter HOLD_CYCLES, default 16: clk_sys cycles that core_reset stays asserted after a ROM load ends.
REQ-003 clk_sys  in  1  system clock; all logic is on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ioctl_download  in  1  loader download active.
REQ-006 ioctl_index  in  8  download target: 0 = ROM, 1 = mod, 254 = DIP.
REQ-007 ioctl_wr  in  1  one-cycle write strobe.
REQ-008 ioctl_addr  in  25  write byte address.
REQ-009 ioctl_dout  in  8  write data.
REQ-010 ioctl_wait  out  1  back-pressure to the loader.
REQ-011 dn_addr  out  16  ROM port address.
REQ-012 dn_data  out  8  ROM port data.
REQ-013 dn_wr  out  1  ROM port write valid.
REQ-014 dn_ready  in  1  ROM port accepts a write this cycle.
REQ-015 mod  out  8  game-variant selector.
REQ-016 sw  out  64  DIP bank; byte k is sw[8k+7:8k].
REQ-017 core_reset  out  1  holds the game core in reset.
REQ-018 overflow  out  1  sticky flag: a ROM write was dropped.

Function
REQ-019 ROM writes: ioctl_wr, index 0 and ioctl_addr[24:16]==0 push {addr[15:0], dout} into the FIFO; writes with addr[24:16]!=0 are discarded.
REQ-020 Output register: it loads from the FIFO head when empty or when it transfers (dn_wr & dn_ready); a push into an empty FIFO with an empty register gives dn_wr=1 on the next cycle.
REQ-021 dn_wr, dn_addr and dn_data hold stable until dn_wr & dn_ready; exactly one transfer per accepted cycle; order is preserved.
REQ-022 Flow control: ioctl_wait=1 whenever FIFO occupancy >= FIFO_DEPTH-1 (registered).
REQ-023 Push to a full FIFO: the entry is dropped and overflow is set; overflow clears on the next rising edge of ioctl_download with index 0.
REQ-024 Simultaneous push and pop: occupancy is unchanged and both take effect.
REQ-025 mod: ioctl_wr with index 1 loads dout into mod on the next edge; the last write wins.
REQ-026 DIP: ioctl_wr with index 254 and addr[24:3]==0 writes byte addr[2:0] of sw; other addresses are ignored.
REQ-027 The FSM has four states: IDLE, LOAD, DRAIN, HOLD.
REQ-028 IDLE -> LOAD: ioctl_download=1 and index 0.
REQ-029 LOAD -> DRAIN: ioctl_download falls.
REQ-030 DRAIN -> HOLD: FIFO and output register are both empty.
REQ-031 HOLD: counts HOLD_CYCLES cycles, then -> IDLE.
REQ-032 HOLD -> LOAD: a new index-0 download starts; the hold counter restarts on the next entry to HOLD.
REQ-033 core_reset=1 exactly in LOAD, DRAIN and HOLD (registered).
REQ-034 Downloads with index 1 or 254 do not change the FSM state or core_reset.

Reset
REQ-035 While reset_n=0, all outputs take their reset values asynchronously: dn_wr=0, dn_addr=0, dn_data=0, ioctl_wait=0, mod=0, sw=all 8'hFF, overflow=0, core_reset=1.
REQ-036 While reset_n=0, the FIFO is emptied and the FSM is in HOLD with counter 0.
REQ-037 Assertion of reset mid-transfer discards all pending ROM writes.

Configuration
REQ-038 With macro IOCTL_SCHED_ROMSUM_EN defined, output rom_sum (16 bits) exists.
REQ-039 rom_sum is the modulo-2^16 sum of every byte transferred on the ROM port; it clears on entry to LOAD and is stable in IDLE.
REQ-040 With IOCTL_SCHED_ROMSUM_EN undefined, the rom_sum port and its logic are absent; all other behaviour is identical.

Verification
REQ-041 Reset release, no activity -> core_reset=1 for 16 cycles then 0; sw=64'hFFFF_FFFF_FFFF_FFFF; mod=0.
REQ-042 Index 0, 256 writes, addr 0..255, data=addr, dn_ready tied 1 -> 256 in-order dn_wr transfers; first transfer 1 cycle after the first ioctl_wr; overflow=0; rom_sum=16'h7F80.
REQ-043 dn_ready=0 and 4 back-to-back ROM writes -> ioctl_wait=1 after the 3rd; a forced 5th write is dropped and overflow=1; dn_ready=1 -> 4 transfers.
REQ-044 Index 254: writes at addr 2 (8'h5A) and addr 9 (8'h00) -> sw[23:16]=8'h5A; every other byte stays 8'hFF; core_reset unchanged.
REQ-045 ioctl_download falls with 2 entries still pending and dn_ready=0 -> FSM stays in DRAIN with core_reset=1; dn_ready=1 -> 2 transfers, then 16 cycles of HOLD, then core_reset=0.
REQ-046 reset_n pulsed low during LOAD with 3 pending entries -> dn_wr=0 immediately; no stale transfer occurs after release.
